// File: rtl/apb_master.sv
// APB master: turns single cmd_valid/cmd_ready commands into APB IDLE/SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  // Command side: a command moves when cmd_valid && cmd_ready at a rising pclk edge;
  // cmd_ready is high only in IDLE and nothing is queued while a transfer is in flight.
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [8:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  // APB side
  output logic [8:0] paddr,
  output logic       pwrite,
  output logic [7:0] pwdata,
  output logic       psel,
  output logic       penable,
  input  logic [7:0] prdata,
  input  logic       pready,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  state_e     state_q, state_d;
  logic [8:0] paddr_q, paddr_d;
  logic       pwrite_q, pwrite_d;
  logic [7:0] pwdata_q, pwdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       xfer_done;
  logic       timeout_hit;

  assign xfer_done = (state_q == ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_error_q;

  // Fires on the last unanswered ACCESS cycle, so ACCESS lasts exactly TIMEOUT_CYCLES.
  assign timeout_hit = (state_q == ACCESS) && !pready &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ACCESS) && !pready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt_q       <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rsp_error_q <= timeout_hit;
    end
  end

  assign rsp_error = rsp_error_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_error   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_write ? cmd_wdata : 8'h00;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (xfer_done) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          if (!pwrite_q) begin
            rsp_rdata_d = prdata;
          end
        end else if (timeout_hit) begin
          // Abort: response carries the error flag, read data is left untouched.
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      paddr_q     <= 9'h000;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Phase strobes decode straight from the state register so reset clears them at once.
  assign psel        = (state_q != IDLE);
  assign penable     = (state_q == ACCESS);
  assign cmd_ready   = (state_q == IDLE);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master: write, read-back, waits, reset, back-to-back.
module tb_apb_master;

  logic       pclk;
  logic       presetn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [8:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic [8:0] paddr;
  logic       pwrite;
  logic [7:0] pwdata;
  logic       psel;
  logic       penable;
  logic [7:0] prdata;
  logic       pready;
  logic [1:0] dbg_state_o;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int rsp_cnt  = 0;
  int exp_rsp  = 0;
  int last_acc = 0;

  logic [7:0] mem [0:511];
  logic [7:0] exp_rdata;

  apb_master #(.TIMEOUT_CYCLES(4)) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .psel        (psel),
    .penable     (penable),
    .prdata      (prdata),
    .pready      (pready),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;
  always @(negedge pclk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One full transfer, entered in an IDLE cycle just after a clock edge.
  // waits = ACCESS cycles with pready low before the ready cycle.
  // chain = leave cmd_valid high so the next call is accepted in the response cycle.
  task automatic xfer(input bit wr, input logic [8:0] a, input logic [7:0] wd,
                      input int waits, input bit chain, input string tag);
    logic [7:0] exp_pwdata;
    exp_pwdata = wr ? wd : 8'h00;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    check({tag, "_cmd_ready_idle"}, cmd_ready, 1);
    tick();
    last_acc = cyc;
    // SETUP: a different pending command and a stray pready must both be ignored
    cmd_write = ~wr;
    cmd_addr  = ~a;
    cmd_wdata = ~wd;
    pready    = 1'b1;
    check({tag, "_setup_state"}, {psel, penable, cmd_ready}, 3'b100);
    check({tag, "_setup_paddr"}, paddr, a);
    check({tag, "_setup_pwrite"}, pwrite, wr);
    check({tag, "_setup_pwdata"}, pwdata, exp_pwdata);
    tick();
    for (int i = 0; i <= waits; i++) begin
      check({tag, "_access_state"}, {psel, penable, cmd_ready, rsp_valid}, 4'b1100);
      check({tag, "_access_addr"}, {paddr, pwrite, pwdata}, {a, wr, exp_pwdata});
      pready = (i == waits);
      prdata = (i == waits) ? mem[a] : (8'h5A ^ 8'(i));
      tick();
    end
    if (wr) mem[a] = wd;
    else exp_rdata = prdata;
    exp_rsp++;
    pready = 1'b0;
    prdata = 8'hEE;
    check({tag, "_done_state"}, {psel, penable, cmd_ready}, 3'b001);
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_rsp_error"}, rsp_error, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
    if (!chain) begin
      cmd_valid = 1'b0;
      tick();
      check({tag, "_rsp_pulse_end"}, {rsp_valid, psel}, 2'b00);
    end
  endtask

  initial begin
    int acc_a;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 7 + 3);
    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 9'h000;
    cmd_wdata = 8'h00;
    prdata    = 8'h00;
    pready    = 1'b0;
    exp_rdata = 8'h00;

    repeat (2) @(posedge pclk);
    #1;
    check("reset_outputs", {psel, penable, pwrite, rsp_valid, rsp_error}, 5'b00000);
    check("reset_data", {paddr, pwdata, rsp_rdata}, 25'h0);
    check("reset_state", dbg_state_o, 2'd0);
    presetn = 1'b1;
    tick();
    check("cmd_ready_after_reset", cmd_ready, 1);

    // zero-wait write 0x1A5 <= 0x3C; prdata garbage must not reach rsp_rdata
    xfer(1'b1, 9'h1A5, 8'h3C, 0, 1'b0, "wr1a5");
    // registered-pready read-back: ACCESS held two cycles
    xfer(1'b0, 9'h1A5, 8'h99, 1, 1'b0, "rd1a5");
    check("readback_value", rsp_rdata, 8'h3C);
    // five wait states on a read and on a write
    xfer(1'b0, 9'h003, 8'h00, 5, 1'b0, "rd_wait5");
    xfer(1'b1, 9'h0FF, 8'hA7, 5, 1'b0, "wr_wait5");
    check("write_keeps_rdata", rsp_rdata, exp_rdata);

    // back-to-back with cmd_valid held: accepted every 3 cycles
    xfer(1'b1, 9'h010, 8'h11, 0, 1'b1, "b2b0");
    acc_a = last_acc;
    xfer(1'b1, 9'h011, 8'h22, 0, 1'b1, "b2b1");
    check("b2b_spacing_01", last_acc - acc_a, 3);
    acc_a = last_acc;
    xfer(1'b0, 9'h010, 8'h00, 0, 1'b0, "b2b2");
    check("b2b_spacing_12", last_acc - acc_a, 3);
    check("b2b_read_data", rsp_rdata, 8'h11);

`ifdef APB_MASTER_TIMEOUT_EN
    // no pready: ACCESS lasts exactly 4 cycles, then error response
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 9'h020;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("tmo_access", {psel, penable, rsp_valid}, 3'b110);
      prdata = 8'hC3;
      tick();
    end
    exp_rsp++;
    check("tmo_idle", {psel, penable, cmd_ready}, 3'b001);
    check("tmo_rsp", {rsp_valid, rsp_error}, 2'b11);
    check("tmo_rdata_kept", rsp_rdata, exp_rdata);
    tick();
    check("tmo_pulse_end", {rsp_valid, rsp_error}, 2'b00);
`else
    // without the timeout ACCESS waits indefinitely
    xfer(1'b0, 9'h020, 8'h00, 20, 1'b0, "long_wait");
`endif

    // reset while penable is high
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 9'h155;
    cmd_wdata = 8'h77;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rst_mid_penable", {psel, penable}, 2'b11);
    #2;
    presetn = 1'b0;
    #1;
    check("rst_async_strobes", {psel, penable}, 2'b00);
    check("rst_async_regs", {paddr, pwdata, rsp_rdata, pwrite}, 26'h0);
    exp_rdata = 8'h00;
    pready = 1'b1;
    tick();
    tick();
    #3;
    presetn = 1'b1;
    pready  = 1'b0;
    tick();
    check("rst_release_ready", cmd_ready, 1);
    check("rst_no_rsp", {rsp_valid, psel}, 2'b00);
    tick();
    check("rst_no_rsp_late", rsp_valid, 0);

    // post-reset sanity transfer
    xfer(1'b0, 9'h1A5, 8'h00, 0, 1'b0, "post_rst_rd");
    check("post_rst_rdata", rsp_rdata, 8'h3C);

    tick();
    check("rsp_pulse_count", rsp_cnt, exp_rsp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // hard time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, number of ACCESS cycles without pready before abort; used only with APB_MASTER_TIMEOUT_EN.
REQ-002 Port: pclk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port: presetn, input, 1, asynchronous active-low reset.
REQ-004 Port: cmd_valid, input, 1, command request.
REQ-005 Port: cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready.
REQ-006 Port: cmd_write, input, 1, 1 = write, 0 = read.
REQ-007 Port: cmd_addr, input, 9, target address.
REQ-008 Port: cmd_wdata, input, 8, write data.
REQ-009 Port: rsp_valid, output, 1, one-cycle completion pulse.
REQ-010 Port: rsp_rdata, output, 8, read data; holds its value until the next read completes.
REQ-011 Port: rsp_error, output, 1, timeout flag qualified by rsp_valid; tied 0 without APB_MASTER_TIMEOUT_EN.
REQ-012 Port: paddr, output, 9, APB address.
REQ-013 Port: pwrite, output, 1, APB write strobe.
REQ-014 Port: pwdata, output, 8, APB write data.
REQ-015 Port: psel, output, 1, APB select.
REQ-016 Port: penable, output, 1, APB enable.
REQ-017 Port: prdata, input, 8, APB read data.
REQ-018 Port: pready, input, 1, APB ready.

Function
REQ-019 FSM states:
- IDLE: psel=0, penable=0.
- SETUP: psel=1, penable=0.
- ACCESS: psel=1, penable=1.
REQ-020 cmd_ready shall be 1 only in IDLE; a handshake in IDLE latches cmd_write, cmd_addr and cmd_wdata into paddr, pwrite and pwdata, and moves the FSM to SETUP.
REQ-021 SETUP shall last exactly one cycle, then move to ACCESS.
REQ-022 ACCESS shall hold while pready=0; paddr, pwrite and pwdata shall stay stable from SETUP through the end of ACCESS.
REQ-023 On pready=1 in ACCESS:
- the FSM returns to IDLE;
- rsp_valid pulses high in the next cycle;
- on a read, rsp_rdata is loaded from that cycle's prdata.
REQ-024 Minimum command-to-command spacing: IDLE, SETUP, ACCESS is 3 cycles with a zero-wait slave; any slave with a registered pready adds 1 wait cycle.
REQ-025 pwdata shall be driven 0 for reads; rsp_rdata shall be unchanged by writes.
REQ-026 cmd_valid in SETUP or ACCESS shall be ignored (cmd_ready=0); no command is queued.
REQ-027 pready asserted outside ACCESS shall be ignored.
REQ-028 rsp_valid and cmd_ready may both be high in the same cycle; a new command accepted in that cycle is legal.

Reset
REQ-029 presetn=0 shall immediately force the following, regardless of in-flight transfer:
- FSM to IDLE;
- psel, penable, pwrite, rsp_valid and rsp_error to 0;
- paddr, pwdata and rsp_rdata to 0;
- timeout counter to 0.
REQ-030 A transfer interrupted by reset shall produce no rsp_valid.
REQ-031 cmd_ready shall be 1 from the first clock edge after presetn deasserts.

Configuration
REQ-032 Macro APB_MASTER_TIMEOUT_EN, when defined, enables the timeout path:
- a counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0;
- when it reaches TIMEOUT_CYCLES, the FSM returns to IDLE and rsp_valid pulses with rsp_error=1;
- rsp_rdata is unchanged on a timeout.
REQ-033 Without APB_MASTER_TIMEOUT_EN, ACCESS shall wait indefinitely for pready, no counter logic shall exist, and rsp_error shall be constant 0.

Verification
REQ-034 Write: cmd write addr=0x1A5, wdata=0x3C, zero-wait slave -> SETUP then ACCESS with paddr=0x1A5, pwdata=0x3C, pwrite=1; rsp_valid one cycle after the pready cycle, rsp_error=0.
REQ-035 Read-back: write 0x1A5=0x3C, then read 0x1A5 with a registered-pready slave -> ACCESS held 2 cycles; rsp_rdata=0x3C.
REQ-036 Wait states: pready held low 5 ACCESS cycles -> psel, penable, paddr and pwdata stable throughout; exactly one rsp_valid pulse.
REQ-037 Reset mid-ACCESS: presetn low while penable=1 -> psel and penable 0 asynchronously, no rsp_valid, cmd_ready=1 after release.
REQ-038 Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4): pready never asserted -> return to IDLE after 4 ACCESS cycles; rsp_valid=1, rsp_error=1, rsp_rdata unchanged.
REQ-039 Back-to-back: cmd_valid held high for 3 commands with a zero-wait slave -> accepted every 3 cycles, 3 rsp_valid pulses in order, no command dropped.
